// File: rtl/async_reset_skid_reg_if.sv
// Handshake bundle for async_reset_skid_reg: upstream din side, downstream dout side, occupancy.
// master = the environment driving din and consuming dout; slave = the skid register itself.
interface async_reset_skid_reg_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] din;
    logic                  din_vld;
    logic                  din_rd;
    logic [DATA_WIDTH-1:0] dout;
    logic                  dout_vld;
    logic                  dout_rd;
    logic [1:0]            occupancy;

    modport master (
        output din, din_vld, dout_rd,
        input  din_rd, dout, dout_vld, occupancy
    );

    modport slave (
        input  din, din_vld, dout_rd,
        output din_rd, dout, dout_vld, occupancy
    );
endinterface

// File: rtl/async_reset_skid_reg.sv
// Two-entry skid register: fully registered outputs, din_rd driven from state only, so upstream
// ready never waits on downstream ready. Words leave strictly in acceptance order.
module async_reset_skid_reg #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    async_reset_skid_reg_if.slave bus
);
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                state, state_next;
    logic [DATA_WIDTH-1:0] main_q, main_next;
    logic [DATA_WIDTH-1:0] skid_q, skid_next;
    logic                  in_xfer;
    logic                  out_xfer;

    // rst gates din_rd so nothing is offered as accepted while reset is held.
    assign bus.din_rd    = (state != FULL) && !rst;
    assign bus.dout_vld  = (state != EMPTY);
    assign bus.dout      = main_q;
    assign bus.occupancy = state;

    assign in_xfer  = bus.din_vld && bus.din_rd;
    assign out_xfer = bus.dout_vld && bus.dout_rd;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves one unassigned (no latch).
        state_next = state;
        main_next  = main_q;
        skid_next  = skid_q;
        unique case (state)
            EMPTY: begin
                if (in_xfer) begin
                    main_next  = bus.din;
                    state_next = ONE;
                end
            end
            ONE: begin
                if (in_xfer && out_xfer) begin
                    main_next = bus.din;
                end else if (in_xfer) begin
                    skid_next  = bus.din;
                    state_next = FULL;
                end else if (out_xfer) begin
                    state_next = EMPTY;
                end
            end
            FULL: begin
                if (out_xfer) begin
                    main_next  = skid_q;
                    state_next = ONE;
                end
            end
            default: state_next = EMPTY;
        endcase
    end

    // NOTE: state uses non-blocking assignments; the data registers are reset too so dout reads 0 in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= EMPTY;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            state  <= state_next;
            main_q <= main_next;
            skid_q <= skid_next;
        end
    end
endmodule

// File: tb/tb_async_reset_skid_reg.sv
// Self-checking bench: 8- and 32-bit instances driven in lockstep, compared against a queue model
// plus hand-computed expectations for the directed scenarios.
module tb_async_reset_skid_reg;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    async_reset_skid_reg_if #(.DATA_WIDTH(8))  bus8 ();
    async_reset_skid_reg_if #(.DATA_WIDTH(32)) bus32 ();

    async_reset_skid_reg #(.DATA_WIDTH(8)) dut8 (
        .clk (clk),
        .rst (rst),
        .bus (bus8)
    );

    async_reset_skid_reg #(.DATA_WIDTH(32)) dut32 (
        .clk (clk),
        .rst (rst),
        .bus (bus32)
    );

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_acc    = 0;
    logic [31:0] model_q[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Hand-computed expectation on the 8-bit instance.
    task automatic expect_out(input string tag, input logic vld, input logic [7:0] data,
                              input logic [1:0] occ, input logic rd);
        check({tag, " dout_vld"},  bus8.dout_vld,  vld);
        if (vld) check({tag, " dout"}, bus8.dout, data);
        check({tag, " occupancy"}, bus8.occupancy, occ);
        check({tag, " din_rd"},    bus8.din_rd,    rd);
    endtask

    // Called at a negedge: compare both DUTs with the model, drive, advance one edge, update model.
    task automatic cycle(input logic vld, input logic [31:0] d, input logic rd);
        int   sz;
        logic acc;
        logic pop;
        logic [31:0] head;
        sz = model_q.size();
        head = (sz > 0) ? model_q[0] : 32'h0;
        check("w8 din_rd",     bus8.din_rd,     sz < 2);
        check("w8 dout_vld",   bus8.dout_vld,   sz > 0);
        check("w8 occupancy",  bus8.occupancy,  sz);
        check("w32 din_rd",    bus32.din_rd,    sz < 2);
        check("w32 dout_vld",  bus32.dout_vld,  sz > 0);
        check("w32 occupancy", bus32.occupancy, sz);
        if (sz > 0) begin
            check("w8 dout",  bus8.dout,  {24'h0, head[7:0]});
            check("w32 dout", bus32.dout, head);
        end
        bus8.din_vld  = vld;
        bus8.din      = d[7:0];
        bus8.dout_rd  = rd;
        bus32.din_vld = vld;
        bus32.din     = d;
        bus32.dout_rd = rd;
        @(posedge clk);
        acc = vld && (sz < 2);
        pop = rd && (sz > 0);
        if (pop) head = model_q.pop_front();
        if (acc) begin
            model_q.push_back(d);
            n_acc++;
        end
        @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 4 && model_q.size() > 0; i++) cycle(1'b0, 32'h0, 1'b1);
        check("drain empty", model_q.size(), 0);
    endtask

    initial begin
        rst = 1'b1;
        bus8.din = '0;  bus8.din_vld = 1'b0;  bus8.dout_rd = 1'b0;
        bus32.din = '0; bus32.din_vld = 1'b0; bus32.dout_rd = 1'b0;
        @(negedge clk);
        @(negedge clk);
        expect_out("reset", 1'b0, 8'h00, 2'd0, 1'b0);
        check("reset dout", bus8.dout, 32'h0);
        rst = 1'b0;
        #1;
        check("post-reset din_rd", bus8.din_rd, 1'b1);
        @(negedge clk);

        // Single word held under backpressure.
        cycle(1'b1, 32'h5A, 1'b0);
        expect_out("single", 1'b1, 8'h5A, 2'd1, 1'b1);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b0);
        expect_out("single held", 1'b1, 8'h5A, 2'd1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        expect_out("single drained", 1'b0, 8'h00, 2'd0, 1'b1);

        // Backpressure: 0x01, 0x02 accepted, 0x03 stalled until a slot frees.
        cycle(1'b1, 32'h01, 1'b0);
        expect_out("bp push1", 1'b1, 8'h01, 2'd1, 1'b1);
        cycle(1'b1, 32'h02, 1'b0);
        expect_out("bp push2", 1'b1, 8'h01, 2'd2, 1'b0);
        cycle(1'b1, 32'h03, 1'b0);
        expect_out("bp stall", 1'b1, 8'h01, 2'd2, 1'b0);
        cycle(1'b1, 32'h03, 1'b1);
        expect_out("bp out1", 1'b1, 8'h02, 2'd1, 1'b1);
        cycle(1'b1, 32'h03, 1'b1);
        expect_out("bp out2", 1'b1, 8'h03, 2'd1, 1'b1);
        cycle(1'b0, 32'h0, 1'b1);
        expect_out("bp out3", 1'b0, 8'h00, 2'd0, 1'b1);

        // Simultaneous input and output while holding one word.
        cycle(1'b1, 32'h10, 1'b0);
        expect_out("simul load", 1'b1, 8'h10, 2'd1, 1'b1);
        cycle(1'b1, 32'h11, 1'b1);
        expect_out("simul swap", 1'b1, 8'h11, 2'd1, 1'b1);
        drain();

        // Streaming: one word per cycle, one-cycle latency.
        for (int i = 0; i < 16; i++) begin
            cycle(1'b1, i, 1'b1);
            expect_out($sformatf("stream %0d", i), 1'b1, i[7:0], 2'd1, 1'b1);
        end
        drain();

        // Random handshakes, both widths in lockstep.
        n_acc = 0;
        for (int c = 0; c < 20000 && n_acc < 1000; c++) begin
            cycle(($urandom_range(0, 3) != 0), $urandom, ($urandom_range(0, 2) != 0));
        end
        check("random words accepted", n_acc, 1000);
        drain();

        // Async reset pulse between edges while FULL.
        cycle(1'b1, 32'hA1, 1'b0);
        cycle(1'b1, 32'hA2, 1'b0);
        expect_out("pre-reset full", 1'b1, 8'hA1, 2'd2, 1'b0);
        bus8.din_vld = 1'b0;
        bus32.din_vld = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_out("mid-cycle reset", 1'b0, 8'h00, 2'd0, 1'b0);
        check("mid-cycle reset dout", bus8.dout, 32'h0);
        check("mid-cycle reset dout w32", bus32.dout, 32'h0);
        #1 rst = 1'b0;
        #1;
        check("reset release din_rd", bus8.din_rd, 1'b1);
        model_q.delete();
        @(negedge clk);
        for (int i = 0; i < 3; i++) cycle(1'b0, 32'h0, 1'b1);
        expect_out("after reset", 1'b0, 8'h00, 2'd0, 1'b1);
        cycle(1'b1, 32'h77, 1'b0);
        expect_out("first after reset", 1'b1, 8'h77, 2'd1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end
endmodule
